// File: rtl/monmult_arb_pkg.sv
// Shared types and default sizing for the MonMult round-robin arbiter.
package monmult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RELEASE
    } state_t;

    localparam int DEFAULT_WIDTH   = 64;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: the first set request bit at or
// after the pointer (wrapping) wins. The pointer register lives in the parent.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    logic [2*NREQ-1:0] rotated;

    // Rotate so the pointer position sits at bit 0, then keep the lowest set bit.
    always_comb begin
        rotated = {req, req} >> ptr;
        valid   = 1'b0;
        winner  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid  = 1'b1;
                winner = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/monmult_arbiter.sv
// Shares one Montgomery multiplier among NREQ requesters: round-robin grant,
// level GO/ready handshake, one-cycle done pulse and a sticky watchdog flag.
module monmult_arbiter
    import monmult_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ*WIDTH-1:0] op_m,
    input  logic                  err_clr,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic [OW-1:0]         owner,
    output logic                  timeout_err,
    output logic                  mm_go,
    output logic [WIDTH-1:0]      mm_a,
    output logic [WIDTH-1:0]      mm_b,
    output logic [WIDTH-1:0]      mm_m,
    input  logic [WIDTH-1:0]      mm_p,
    input  logic                  mm_ready
);

    localparam int WDW = $clog2(TIMEOUT);

    state_t           state;
    logic [OW-1:0]    ptr;
    logic [WDW-1:0]   wdog;
    logic             abandoned;
    logic             pick_valid;
    logic [OW-1:0]    pick_idx;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] m_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = op_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = op_b[i*WIDTH +: WIDTH];
        assign m_arr[i] = op_m[i*WIDTH +: WIDTH];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Grant/issue/capture/release sequencing; every output is a register here.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            wdog        <= '0;
            abandoned   <= 1'b0;
            done        <= '0;
            result      <= '0;
            busy        <= 1'b0;
            owner       <= '0;
            timeout_err <= 1'b0;
            mm_go       <= 1'b0;
            mm_a        <= '0;
            mm_b        <= '0;
            mm_m        <= '0;
        end else begin
            done <= '0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        mm_a      <= a_arr[pick_idx];
                        mm_b      <= b_arr[pick_idx];
                        mm_m      <= m_arr[pick_idx];
                        mm_go     <= 1'b1;
                        busy      <= 1'b1;
                        wdog      <= '0;
                        abandoned <= 1'b0;
                        if (pick_idx == OW'(NREQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= pick_idx + OW'(1);
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!req[owner]) begin
                        abandoned <= 1'b1;
                    end
                    if (mm_ready) begin
                        state <= CAPTURE;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        timeout_err  <= 1'b1;
                        result       <= '0;
                        done[owner]  <= 1'b1;
                        mm_go        <= 1'b0;
                        state        <= RELEASE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                CAPTURE: begin
                    mm_go <= 1'b0;
                    if (!abandoned) begin
                        result      <= mm_p;
                        done[owner] <= 1'b1;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!mm_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monmult_arbiter.sv
// Self-checking bench for monmult_arbiter with a 5-cycle MonMult stand-in and
// a round-robin/modular-product reference model.
module tb_monmult_arbiter;

    localparam int NREQ    = 2;
    localparam int WIDTH   = 64;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 5;
    localparam int MAXWAIT = 200;

    logic         pclk;
    logic         reset;
    logic [1:0]   req;
    logic [127:0] op_a, op_b, op_m;
    logic         err_clr;
    logic [1:0]   done;
    logic [63:0]  result;
    logic         busy;
    logic [0:0]   owner;
    logic         timeout_err;
    logic         mm_go;
    logic [63:0]  mm_a, mm_b, mm_m;
    logic [63:0]  mm_p;
    logic         mm_ready;

    logic [63:0]  ra [2];
    logic [63:0]  rb [2];
    logic [63:0]  rm [2];

    int           n_cmp = 0;
    int           n_fail = 0;
    int           rr_start = 0;
    logic [63:0]  last_result = '0;
    bit           never_ready = 1'b0;
    int           mdl_cnt = 0;

    assign op_a = {ra[1], ra[0]};
    assign op_b = {rb[1], rb[0]};
    assign op_m = {rm[1], rm[0]};

    monmult_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_m        (op_m),
        .err_clr     (err_clr),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err),
        .mm_go       (mm_go),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_m        (mm_m),
        .mm_p        (mm_p),
        .mm_ready    (mm_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, m});
    endfunction

    function automatic int rr_pick(input logic [1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // MonMult stand-in: ready LAT cycles after GO, held until GO drops.
    always @(posedge pclk) begin
        if (!mm_go) begin
            mdl_cnt  <= 0;
            mm_ready <= 1'b0;
        end else if (!mm_ready && !never_ready) begin
            if (mdl_cnt == LAT - 1) begin
                mm_ready <= 1'b1;
                mm_p     <= mulmod(mm_a, mm_b, mm_m);
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    initial begin
        mm_ready = 1'b0;
        mm_p     = '0;
    end

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] m);
        ra[i] = a;
        rb[i] = b;
        rm[i] = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge pclk);
        reset    = 1'b0;
        rr_start = 0;
        last_result = '0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 2'b00;
        err_clr = 1'b0;
        for (int i = 0; i < 2; i++) set_ops(i, '0, '0, 64'd1);
        repeat (3) @(negedge pclk);
        n_cmp++;
        if ({done, busy, owner, timeout_err, mm_go} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {done, busy, owner, timeout_err, mm_go});
        end
        n_cmp++;
        if ({result, mm_a, mm_b, mm_m} !== 256'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: result=%h mm_a=%h mm_b=%h mm_m=%h expected all 0",
                     result, mm_a, mm_b, mm_m);
        end
        reset    = 1'b0;
        rr_start = 0;
    endtask

    task automatic test_single();
        int k_ready = -1;
        int k_done  = -1;
        bit ok;
        set_ops(0, 64'd3, 64'd5, 64'h1F);
        req = 2'b01;
        @(negedge pclk);
        n_cmp++;
        if (mm_go !== 1'b1 || owner !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: go=%b owner=%0d busy=%b expected 1 0 1",
                     mm_go, owner, busy);
        end
        n_cmp++;
        if (mm_a !== 64'd3 || mm_b !== 64'd5 || mm_m !== 64'h1F) begin
            n_fail++;
            $display("[TB] FAIL single_ops: a=%h b=%h m=%h expected 3 5 1f", mm_a, mm_b, mm_m);
        end
        rr_start = 1;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (mm_ready && k_ready < 0) k_ready = i;
            if (done !== 2'b00) begin
                k_done = i;
                break;
            end
        end
        n_cmp++;
        if (done !== 2'b01 || result !== 64'hF) begin
            n_fail++;
            $display("[TB] FAIL single_done: done=%b result=%h expected 01 f", done, result);
        end
        n_cmp++;
        if (k_ready < 0 || k_done - k_ready != 2) begin
            n_fail++;
            $display("[TB] FAIL single_latency: ready->done %0d cycles expected 2",
                     k_done - k_ready);
        end
        last_result = 64'hF;
        req = 2'b00;
        @(negedge pclk);
        n_cmp++;
        if (done !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL single_pulse: done=%b expected 00", done);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL single_release: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int w;
        bit ok;
        logic [63:0] exp_p;
        do_reset();
        for (int i = 0; i < 2; i++) set_ops(i, rand64(), rand64(), rand64() | 64'd1);
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            w        = rr_pick(req, rr_start);
            rr_start = (w + 1) % NREQ;
            exp_p    = mulmod(ra[w], rb[w], rm[w]);
            @(negedge pclk);
            n_cmp++;
            if (owner !== 1'(w) || mm_go !== 1'b1 || w != g % 2) begin
                n_fail++;
                $display("[TB] FAIL rr_grant%0d: owner=%0d go=%b expected owner %0d go 1",
                         g, owner, mm_go, g % 2);
            end
            ok = 1'b0;
            for (int i = 0; i < MAXWAIT; i++) begin
                @(negedge pclk);
                if (done !== 2'b00) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_cmp++;
            if (!ok || done !== 2'(1 << w) || result !== exp_p) begin
                n_fail++;
                $display("[TB] FAIL rr_done%0d: done=%b result=%h expected %b %h",
                         g, done, result, 2'(1 << w), exp_p);
            end
            last_result = exp_p;
            set_ops(w, rand64(), rand64(), rand64() | 64'd1);
            wait_idle(ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL rr_idle%0d: busy=%b expected 0", g, busy);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_operand_change();
        logic [63:0] exp_p;
        bit ok;
        set_ops(1, rand64(), rand64(), rand64() | 64'd1);
        exp_p = mulmod(ra[1], rb[1], rm[1]);
        req   = 2'b10;
        @(negedge pclk);
        n_cmp++;
        if (owner !== 1'b1 || mm_a !== ra[1]) begin
            n_fail++;
            $display("[TB] FAIL opchg_grant: owner=%0d mm_a=%h expected 1 %h", owner, mm_a, ra[1]);
        end
        rr_start = 0;
        ra[1]    = ~ra[1];
        ok = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (done !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || done !== 2'b10 || result !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL opchg_result: done=%b result=%h expected 10 %h", done, result, exp_p);
        end
        last_result = exp_p;
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        int  go_cycles = 0;
        bit  ok;
        never_ready = 1'b1;
        set_ops(0, rand64(), rand64(), rand64() | 64'd1);
        req = 2'b01;
        ok  = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (timeout_err) begin
                ok = 1'b1;
                break;
            end
            if (mm_go) go_cycles++;
        end
        n_cmp++;
        if (!ok || go_cycles != TIMEOUT) begin
            n_fail++;
            $display("[TB] FAIL tmo_cycles: issue cycles=%0d flag=%b expected %0d 1",
                     go_cycles, timeout_err, TIMEOUT);
        end
        n_cmp++;
        if (done !== 2'b01 || result !== 64'd0 || mm_go !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_done: done=%b result=%h go=%b expected 01 0 0",
                     done, result, mm_go);
        end
        last_result = '0;
        rr_start    = 1;
        req = 2'b00;
        @(negedge pclk);
        n_cmp++;
        if (timeout_err !== 1'b1 || done !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL tmo_sticky: flag=%b done=%b expected 1 00", timeout_err, done);
        end
        wait_idle(ok);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_clear: flag=%b expected 0", timeout_err);
        end
        err_clr = 1'b1;
        req     = 2'b01;
        ok      = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (timeout_err) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || done !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL tmo_set_wins: flag=%b done=%b expected 1 01", timeout_err, done);
        end
        req = 2'b00;
        @(negedge pclk);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_clr_after: flag=%b expected 0", timeout_err);
        end
        err_clr     = 1'b0;
        never_ready = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp_p;
        bit ok;
        set_ops(0, rand64(), rand64(), rand64() | 64'd1);
        req = 2'b01;
        repeat (3) @(negedge pclk);
        reset = 1'b1;
        @(negedge pclk);
        reset = 1'b0;
        n_cmp++;
        if (mm_go !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || result !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_state: go=%b busy=%b done=%b result=%h expected 0 0 00 0",
                     mm_go, busy, done, result);
        end
        rr_start = 0;
        set_ops(0, rand64(), rand64(), rand64() | 64'd1);
        set_ops(1, rand64(), rand64(), rand64() | 64'd1);
        exp_p = mulmod(ra[0], rb[0], rm[0]);
        req   = 2'b11;
        @(negedge pclk);
        n_cmp++;
        if (owner !== 1'b0 || mm_go !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rstmid_regrant: owner=%0d go=%b expected 0 1", owner, mm_go);
        end
        rr_start = 1;
        ok = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (done !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || done !== 2'b01 || result !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL rstmid_done: done=%b result=%h expected 01 %h", done, result, exp_p);
        end
        last_result = exp_p;
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_abandon();
        logic [63:0] exp_p;
        bit ok;
        bit saw_done = 1'b0;
        set_ops(0, rand64(), rand64(), rand64() | 64'd1);
        set_ops(1, rand64(), rand64(), rand64() | 64'd1);
        req = 2'b01;
        @(negedge pclk);
        rr_start = 1;
        req = 2'b11;
        repeat (2) @(negedge pclk);
        req = 2'b10;
        ok  = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (done !== 2'b00) saw_done = 1'b1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || saw_done) begin
            n_fail++;
            $display("[TB] FAIL abandon_nodone: saw_done=%b idle=%b expected 0 1", saw_done, ok);
        end
        n_cmp++;
        if (result !== last_result) begin
            n_fail++;
            $display("[TB] FAIL abandon_result: result=%h expected %h", result, last_result);
        end
        exp_p = mulmod(ra[1], rb[1], rm[1]);
        @(negedge pclk);
        n_cmp++;
        if (owner !== 1'b1 || mm_go !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abandon_next: owner=%0d go=%b expected 1 1", owner, mm_go);
        end
        rr_start = 0;
        ok = 1'b0;
        for (int i = 0; i < MAXWAIT; i++) begin
            @(negedge pclk);
            if (done !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || done !== 2'b10 || result !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL abandon_done: done=%b result=%h expected 10 %h", done, result, exp_p);
        end
        last_result = exp_p;
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_random_traffic();
        int          completed = 0;
        int          cyc = 0;
        int          exp_w = -1;
        int          just_done;
        bit          expect_grant = 1'b0;
        bit          in_flight = 1'b0;
        bit          ok;
        logic [63:0] exp_p = '0;
        while (completed < 12 && cyc < 3000) begin
            @(negedge pclk);
            cyc++;
            just_done = -1;
            if (expect_grant) begin
                n_cmp++;
                if (owner !== 1'(exp_w) || mm_go !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL rand_grant: owner=%0d go=%b expected %0d 1",
                             owner, mm_go, exp_w);
                end
                expect_grant = 1'b0;
                in_flight    = 1'b1;
            end
            if (done !== 2'b00) begin
                n_cmp++;
                if (!in_flight || done !== 2'(1 << exp_w) || result !== exp_p) begin
                    n_fail++;
                    $display("[TB] FAIL rand_done: done=%b result=%h expected %b %h",
                             done, result, 2'(1 << exp_w), exp_p);
                end
                if (in_flight) begin
                    req[exp_w] = 1'b0;
                    just_done  = exp_w;
                end
                in_flight   = 1'b0;
                last_result = exp_p;
                completed++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && i != just_done && $urandom_range(0, 3) == 0) begin
                    set_ops(i, rand64(), rand64(), rand64() | 64'd1);
                    req[i] = 1'b1;
                end
            end
            if (!busy && !expect_grant && req != 2'b00) begin
                exp_w        = rr_pick(req, rr_start);
                rr_start     = (exp_w + 1) % NREQ;
                exp_p        = mulmod(ra[exp_w], rb[exp_w], rm[exp_w]);
                expect_grant = 1'b1;
            end
        end
        n_cmp++;
        if (completed < 12) begin
            n_fail++;
            $display("[TB] FAIL rand_progress: completed=%0d expected 12", completed);
        end
        req = 2'b00;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_operand_change();
        test_timeout();
        test_reset_mid();
        test_abandon();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

endmodule
